// File: rtl/linear_layer_start_fifo_rd_pkg.sv
// Shared constants and helpers for the linear_layer_start read-side token FIFO.
package linear_layer_start_fifo_rd_pkg;

  localparam int DEFAULT_DEPTH      = 2;
  localparam int DEFAULT_ADDR_WIDTH = 1;

  // Occupancy counter needs one extra bit so that "full" (cnt == DEPTH) is representable.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/linear_layer_start_fifo_srl.sv
// Token storage: write-enabled shift chain with an addressed combinational read port.
module linear_layer_start_fifo_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

  // Shift chain; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (ce) begin
      mem_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end
  end

  assign dout = mem_r[addr];

endmodule

// File: rtl/linear_layer_start_fifo_rd.sv
// Shift-register token FIFO with registered empty/full flags.
// Optional macro LINEAR_LAYER_START_FIFO_CNT_EN exposes the occupancy count as if_num_data_valid.
module linear_layer_start_fifo_rd
  import linear_layer_start_fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
`ifdef LINEAR_LAYER_START_FIFO_CNT_EN
  ,
  output logic [cnt_width(ADDR_WIDTH)-1:0] if_num_data_valid
`endif
);

  localparam int            CW      = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]         cnt_r;
  logic [CW-1:0]         cnt_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] addr_nxt_s;
  logic                  empty_n_r;
  logic                  full_n_r;
  logic                  wr_s;
  logic                  rd_s;

  assign wr_s = if_write & full_n_r;
  assign rd_s = if_read & empty_n_r;

  // Next occupancy and read address; a simultaneous read+write leaves both unchanged.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({wr_s, rd_s})
      2'b10:   cnt_nxt_s = cnt_r + CW'(1);
      2'b01:   cnt_nxt_s = cnt_r - CW'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
    if (cnt_nxt_s != {CW{1'b0}}) begin
      addr_nxt_s = ADDR_WIDTH'(cnt_nxt_s - CW'(1));
    end else begin
      addr_nxt_s = {ADDR_WIDTH{1'b0}};
    end
  end

  // Control state; reset drops all tokens immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= {CW{1'b0}};
      addr_r    <= {ADDR_WIDTH{1'b0}};
      empty_n_r <= 1'b0;
      full_n_r  <= 1'b1;
    end else begin
      cnt_r     <= cnt_nxt_s;
      addr_r    <= addr_nxt_s;
      empty_n_r <= (cnt_nxt_s != {CW{1'b0}});
      full_n_r  <= (cnt_nxt_s != DEPTH_C);
    end
  end

  linear_layer_start_fifo_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .ce   (wr_s),
    .din  (if_din),
    .addr (addr_r),
    .dout (if_dout)
  );

  assign if_empty_n = empty_n_r;
  assign if_full_n  = full_n_r;

`ifdef LINEAR_LAYER_START_FIFO_CNT_EN
  assign if_num_data_valid = cnt_r;
`endif

endmodule

// File: tb/tb_linear_layer_start_fifo_rd.sv
// Self-checking bench: queue-based FIFO model, directed corner cases, then randomized traffic.
module tb_linear_layer_start_fifo_rd;

  localparam int DW    = 8;
  localparam int AW    = 1;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_write = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n;
  logic          if_read = 1'b0;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
`ifdef LINEAR_LAYER_START_FIFO_CNT_EN
  logic [AW:0]   if_num_data_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] q [$];

  linear_layer_start_fifo_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_write   (if_write),
    .if_din     (if_din),
    .if_full_n  (if_full_n),
    .if_read    (if_read),
    .if_dout    (if_dout),
    .if_empty_n (if_empty_n)
`ifdef LINEAR_LAYER_START_FIFO_CNT_EN
    ,
    .if_num_data_valid (if_num_data_valid)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Compare the DUT against the queue model (outputs reflect the last clock edge).
  task automatic check_model();
    chk("empty_n", 32'(if_empty_n), 32'(q.size() != 0));
    chk("full_n", 32'(if_full_n), 32'(q.size() != DEPTH));
    if (q.size() != 0) chk("dout", 32'(if_dout), 32'(q[0]));
`ifdef LINEAR_LAYER_START_FIFO_CNT_EN
    chk("num_valid", 32'(if_num_data_valid), 32'(q.size()));
`endif
  endtask

  // One clock cycle: check, drive, update model at the edge, return at the next negedge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    bit wa, ra;
    check_model();
    if_write = w; if_din = d; if_read = r;
    wa = w && (q.size() < DEPTH);
    ra = r && (q.size() > 0);
    @(posedge clk);
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(d);
    @(negedge clk);
    if_write = 1'b0; if_read = 1'b0;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_empty_n", 32'(if_empty_n), 32'd0);
    chk("rst_full_n", 32'(if_full_n), 32'd1);
`ifdef LINEAR_LAYER_START_FIFO_CNT_EN
    chk("rst_num_valid", 32'(if_num_data_valid), 32'd0);
`endif
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_empty_n", 32'(if_empty_n), 32'd0);
    chk("reset_full_n", 32'(if_full_n), 32'd1);
    reset_n = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      chk("idle_empty_n", 32'(if_empty_n), 32'd0);
      chk("idle_full_n", 32'(if_full_n), 32'd1);
    end

    // Fill with 1 then 0, drain in order
    cycle(1'b1, 8'h01, 1'b0);
    chk("wr1_empty_n", 32'(if_empty_n), 32'd1);
    chk("wr1_dout", 32'(if_dout), 32'h01);
    cycle(1'b1, 8'h00, 1'b0);
    chk("full_after_2", 32'(if_full_n), 32'd0);
    chk("rd_first", 32'(if_dout), 32'h01);
    cycle(1'b0, 8'h00, 1'b1);
    chk("rd_second", 32'(if_dout), 32'h00);
    cycle(1'b0, 8'h00, 1'b1);
    chk("drained_empty_n", 32'(if_empty_n), 32'd0);

    // Full + simultaneous write/read: only the read is accepted
    cycle(1'b1, 8'hA1, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0);
    cycle(1'b1, 8'hA3, 1'b1);
    chk("full_wr_rd_full_n", 32'(if_full_n), 32'd1);
    chk("full_wr_rd_empty_n", 32'(if_empty_n), 32'd1);
    chk("full_wr_rd_dout", 32'(if_dout), 32'hA2);
    cycle(1'b0, 8'h00, 1'b1);

    // Empty + simultaneous write/read: the write is accepted
    cycle(1'b1, 8'h01, 1'b1);
    chk("empty_wr_rd_empty_n", 32'(if_empty_n), 32'd1);
    chk("empty_wr_rd_dout", 32'(if_dout), 32'h01);

    // Streaming at occupancy 1 with alternating data
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, (i % 2 == 0) ? 8'h55 : 8'hAA, 1'b1);
      chk("stream_empty_n", 32'(if_empty_n), 32'd1);
      chk("stream_full_n", 32'(if_full_n), 32'd1);
    end
    chk("stream_last_dout", 32'(if_dout), 32'hAA);

    // Asynchronous reset while full
    cycle(1'b1, 8'h77, 1'b0);
    chk("pre_rst_full_n", 32'(if_full_n), 32'd0);
    mid_reset();
    cycle(1'b0, 8'h00, 1'b0);

    // Randomized traffic with varying read/write bias and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      wp = ((i / 300) % 2 == 0) ? 70 : 35;
      rp = 100 - wp;
      if ($urandom_range(0, 199) == 0) begin
        mid_reset();
      end else begin
        cycle(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0, 8'($urandom),
              ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0);
      end
    end
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/linear_layer_start_fifo_rd.md
LINEAR_LAYER_START_FIFO_RD -- requirements
Module: linear_layer_start_fifo_rd

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 1, meaning the token width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 1, meaning the read-address width, with 2^ADDR_WIDTH >= DEPTH.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning the token capacity (>= 2).
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-006 Port if_write, input, 1, SHALL be the producer write request.
REQ-007 Port if_din, input, DATA_WIDTH, SHALL be the producer token.
REQ-008 Port if_full_n, output, 1, SHALL be high when a write will be accepted.
REQ-009 Port if_read, input, 1, SHALL be the consumer read request.
REQ-010 Port if_dout, output, DATA_WIDTH, SHALL be the oldest stored token.
REQ-011 Port if_empty_n, output, 1, SHALL be high when if_dout holds a valid token.

Function
REQ-012 Write-accept SHALL be if_write AND if_full_n; read-accept SHALL be if_read AND if_empty_n.
REQ-013 On write-accept, storage SHALL shift by one and if_din SHALL enter slot 0.
REQ-014 An internal occupancy counter cnt (0..DEPTH, ADDR_WIDTH+1 bits) SHALL increment on write-only, decrement on read-only, and hold on both or neither.
REQ-015 Read address SHALL be registered and equal cnt-1 when cnt>0, else 0, so that if_dout = slot[addr] combinationally always shows the oldest token.
REQ-016 if_empty_n and if_full_n SHALL be registered: if_empty_n = (next cnt != 0), if_full_n = (next cnt != DEPTH).
REQ-017 Latency: a token written in cycle N SHALL be visible, with if_empty_n high, in cycle N+1.
REQ-018 Full: if_write with if_full_n low SHALL be ignored, even if a read is accepted that cycle.
REQ-019 Empty: if_read with if_empty_n low SHALL be ignored; a simultaneous write SHALL still be accepted.
REQ-020 Simultaneous accepted read and write SHALL keep cnt and addr unchanged; if_dout SHALL then show the next-oldest token.
REQ-021 The counter SHALL never wrap: cnt SHALL stay within 0..DEPTH under any input sequence.

Reset
REQ-022 While reset_n is low: cnt=0, addr=0, if_empty_n=0, if_full_n=1.
REQ-023 Storage contents SHALL NOT be reset; if_dout is don't-care while if_empty_n=0.
REQ-024 Reset asserted mid-operation SHALL discard all tokens immediately, without waiting for a clock edge.

Configuration
REQ-025 Macro LINEAR_LAYER_START_FIFO_CNT_EN SHALL, when defined, add output port if_num_data_valid (ADDR_WIDTH+1 bits) equal to registered cnt; reset value 0.
REQ-026 Without LINEAR_LAYER_START_FIFO_CNT_EN the port SHALL be absent and behaviour otherwise identical.

Structure
REQ-027 A shared package SHALL hold the counter-width function (ADDR_WIDTH+1) and the default DEPTH/ADDR_WIDTH constants.
REQ-028 Token storage SHALL be a sub-module linear_layer_start_fifo_srl (write-enable shift chain, addressed combinational read); all control logic SHALL stay in the top.

Verification
REQ-029 Release reset, no stimulus -> if_empty_n=0, if_full_n=1 for 10 cycles.
REQ-030 Write tokens 1 then 0 (DEPTH=2) -> if_full_n=0 after second write; reads return 1 then 0; if_empty_n=0 afterwards.
REQ-031 Full (DEPTH=2), assert if_write and if_read together -> only the read is accepted; cnt=1, if_full_n=1 next cycle.
REQ-032 Empty, assert if_write (din=1) and if_read together -> write accepted, if_empty_n=1, if_dout=1 next cycle.
REQ-033 cnt=1, continuous simultaneous read+write for 20 cycles with alternating data -> if_empty_n stays 1, if_full_n stays 1, data order preserved.
REQ-034 Assert reset_n low mid-cycle with FIFO full -> if_empty_n=0, if_full_n=1 before the next clock edge; with CNT_EN, if_num_data_valid=0.
